// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues imem reads, buffers
// fetched words with their PCs in a prefetch FIFO, and handles redirect and HALT.
module ifetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0,
  parameter int          DEPTH   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [5:0]    OP_HALT  = 6'b111111;

  typedef enum logic [1:0] {S_FETCH, S_FULL, S_HALTED} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic push, pop, halt_pop, redirect_take;
  logic unused_rpc_lsbs;

  assign unused_rpc_lsbs = ^redirect_pc[1:0];

  assign imemaddr   = fetch_pc_q;
  assign imemREN    = (state_q == S_FETCH) && (count_q < CNT_FULL) && !redirect;
  assign inst_valid = (state_q != S_HALTED) && (count_q != '0);
  assign inst       = inst_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign halted     = (state_q == S_HALTED);

  assign pop           = inst_valid && inst_ready;
  assign halt_pop      = pop && (inst[31:26] == OP_HALT);
  assign redirect_take = redirect && (state_q != S_HALTED);
  // A word returned in the HALT-pop cycle is dropped along with the flush.
  assign push          = imemREN && ihit && !halt_pop;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (halt_pop) begin
      state_d  = S_HALTED;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (redirect_take) begin
      state_d    = S_FETCH;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end

      unique case (state_q)
        S_FETCH: if (count_d == CNT_FULL) state_d = S_FULL;
        S_FULL:  if (pop) state_d = S_FETCH;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= PC_INIT;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: the FIFO storage is reset because inst/inst_pc must read 0 out of reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      inst_mem_q[wr_ptr_q] <= imemload;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_ifetch_unit;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] PC_INIT = 32'h0;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halted;

  ifetch_unit #(.PC_INIT(PC_INIT), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } entry_t;

  entry_t      q[$];
  logic [31:0] m_pc;
  logic        m_halted;
  logic        halt_en;
  logic [31:0] halt_addr;

  // Instruction memory image: word = address + 0x100, except one optional HALT word.
  function automatic logic [31:0] word_at(input logic [31:0] a, input logic en,
                                          input logic [31:0] ha);
    if (en && a == ha) return 32'hFC00_0000;
    return a + 32'h100;
  endfunction

  assign imemload = word_at(imemaddr, halt_en, halt_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input logic hit, input logic rdy, input logic rd, input logic [31:0] rpc);
    logic   ren, vld, pop;
    entry_t head;
    @(negedge CLK);
    ihit        = hit;
    inst_ready  = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    ren = !m_halted && (q.size() < DEPTH) && !rd;
    vld = !m_halted && (q.size() != 0);
    check("imemREN", imemREN, ren);
    check("inst_valid", inst_valid, vld);
    check("halted", halted, m_halted);
    if (!m_halted) check("imemaddr", imemaddr, m_pc);
    if (vld) begin
      check("inst", inst, q[0].ins);
      check("inst_pc", inst_pc, q[0].pc);
    end
    @(posedge CLK);
    pop  = vld && rdy;
    head = '0;
    if (pop) head = q.pop_front();
    if (pop && head.ins[31:26] == 6'h3F) begin
      m_halted = 1'b1;
      q.delete();
    end else if (rd && !m_halted) begin
      q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else if (ren && hit) begin
      q.push_back('{pc: m_pc, ins: word_at(m_pc, halt_en, halt_addr)});
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Asynchronous reset, asserted and released away from any clock edge.
  task automatic do_reset(input logic hen, input logic [31:0] ha);
    #3;
    RST         = 1'b1;
    ihit        = 1'b0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt_en     = hen;
    halt_addr   = ha;
    #1;
    check("rst_imemaddr", imemaddr, PC_INIT);
    check("rst_inst_valid", inst_valid, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_halted", halted, 32'd0);
    check("rst_imemREN", imemREN, 32'd1);
    q.delete();
    m_pc     = PC_INIT;
    m_halted = 1'b0;
    repeat (2) @(negedge CLK);
    #2;
    RST = 1'b0;
  endtask

  initial begin
    // Zero-wait streaming.
    do_reset(1'b0, '0);
    repeat (12) step(1'b1, 1'b1, 1'b0, '0);

    // Backpressure fills the FIFO, then drains in order.
    do_reset(1'b0, '0);
    repeat (5) step(1'b1, 1'b0, 1'b0, '0);
    repeat (6) step(1'b1, 1'b1, 1'b0, '0);

    // Wait states: a hit every third cycle.
    for (int i = 0; i < 15; i++) step(i % 3 == 0, 1'b1, 1'b0, '0);

    // Redirect with a full FIFO and ihit high; then a redirect near the top of memory to wrap.
    do_reset(1'b0, '0);
    repeat (2) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0043);
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9);
    repeat (6) step(1'b1, 1'b1, 1'b0, '0);

    // HALT at PC 12, then a redirect pulse that must be ignored.
    do_reset(1'b1, 32'd12);
    repeat (8) step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    repeat (3) step(1'b1, 1'b1, 1'b0, '0);
    check("halt_sticky", halted, 32'd1);
    check("halt_no_ren", imemREN, 32'd0);

    // Mid-stream asynchronous reset with a non-empty FIFO, then restart.
    do_reset(1'b0, '0);
    repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    check("pre_rst_valid", inst_valid, 32'd1);
    do_reset(1'b0, '0);
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);

    // Random traffic without HALT.
    do_reset(1'b0, '0);
    repeat (400) step($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 12 == 0,
                      $urandom & 32'h0000_FFFF);

    // Random traffic in a small address window so the HALT word is eventually popped.
    do_reset(1'b1, 32'h20);
    repeat (300) step($urandom % 3 != 0, $urandom % 3 != 0, $urandom % 10 == 0,
                      $urandom & 32'h0000_003F);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch front end of the single-cycle/pipelined datapath. It owns the fetch program counter and drives instruction-memory read requests (`imemREN`/`imemaddr`), accepting `imemload` on `ihit`. Fetched words are buffered with their PCs in a small prefetch FIFO and handed to decode over a valid/ready handshake. It also handles branch/jump redirects and stops fetching permanently once a HALT instruction is delivered.

## Interface

Parameters:
- `PC_INIT`, default 32'h0: PC loaded on reset.
- `DEPTH`, default 2: prefetch FIFO entries; power of two, at least 2.

Ports:
- `CLK`  in  1  Clock; all state updates on its rising edge.
- `RST`  in  1  Asynchronous, active-high reset.
- `imemREN`  out  1  Instruction read request.
- `imemaddr`  out  32  Read address, always word aligned (`[1:0]`=0).
- `ihit`  in  1  Memory returns `imemload` for `imemaddr` this cycle; may be high in the same cycle `imemREN` rises.
- `imemload`  in  32  Instruction word; valid only when `ihit && imemREN`.
- `inst_valid`  out  1  FIFO head is valid.
- `inst`  out  32  FIFO head instruction.
- `inst_pc`  out  32  FIFO head PC.
- `inst_ready`  in  1  Decode accepts the head; a pop occurs when `inst_valid && inst_ready`.
- `redirect`  in  1  Branch/jump taken; flush and refetch.
- `redirect_pc`  in  32  Target; bits `[1:0]` ignored and forced to 0.
- `halted`  out  1  HALT delivered; fetch stopped.

## Operation

- State: `fetch_pc` (32b), FIFO of `{pc, inst}` with `DEPTH` entries, read/write pointers, count of `$clog2(DEPTH)+1` bits, and an FSM with states FETCH, FULL, HALTED.
- `imemaddr` = `fetch_pc` at all times. `imemREN` = 1 only in FETCH with `count < DEPTH` and `redirect`=0.
- Accept: `imemREN && ihit` pushes `{fetch_pc, imemload}`, and `fetch_pc <= fetch_pc + 4` (32-bit wrap: 32'hFFFFFFFC goes to 0).
- Pop: `inst_valid && inst_ready` advances the read pointer. Push and pop in the same cycle leave the count unchanged.
- FSM:
  - FETCH -> FULL when the count reaches `DEPTH` without a pop.
  - FULL -> FETCH on any pop. `imemREN` stays low in FULL, so there is no push in the pop cycle.
- Redirect (any state except HALTED):
  - Clears the FIFO, so count=0 next cycle.
  - `fetch_pc <= {redirect_pc[31:2],2'b00}`.
  - Any `ihit` in that cycle is discarded.
  - A pop in the same cycle still counts as delivered to decode.
  - Next state is FETCH.
- HALT: when a popped `inst[31:26]` = 6'b111111 (HALT):
  - Next state is HALTED and `halted`=1.
  - The FIFO is flushed, `imemREN`=0 and `inst_valid`=0.
  - `redirect` is ignored.
  - Only `RST` leaves HALTED.
- HALT priority: redirect and HALT pop in the same cycle resolve as HALT.
- Reset: async `RST` immediately forces the FIFO empty, `fetch_pc`=`PC_INIT`, state FETCH and `halted`=0. Any in-flight request is abandoned.

## Timing

- Reset values of outputs:
  - `imemREN`=1 after `RST` falls; it is combinational from the FETCH state.
  - `imemaddr`=`PC_INIT`.
  - `inst_valid`=0, `inst`=0, `inst_pc`=0 (FIFO storage cleared).
  - `halted`=0.
- Latency: a word accepted on `ihit` in cycle N appears at the head with `inst_valid`=1 in cycle N+1. There is no combinational bypass from `imemload` to `inst`.
- With zero-wait memory (`ihit` tied 1) and `inst_ready`=1, throughput is 1 instruction/cycle. The first `inst_valid` occurs in the first cycle after reset release plus one.
- `inst`/`inst_pc` remain stable while `inst_valid && !inst_ready`.
- `imemaddr` changes only on an accepted word, a redirect, or reset.
- After a redirect in cycle N, the first target instruction is valid no earlier than N+2.

## Test plan

1. Reset, `PC_INIT`=0, `ihit`=1, `inst_ready`=1, memory returns word = address + 32'h100 -> `inst_pc` sequence 0,4,8,… with `inst` = 32'h100,104,…, one per cycle starting in the 2nd cycle.
2. Backpressure: `inst_ready`=0 for 5 cycles -> exactly 2 pushes (PCs 0,4), FULL state and `imemREN`=0. Raise ready -> PCs 0,4,8 are delivered in order with no loss or duplicate.
3. Wait states: `ihit` high every 3rd cycle -> `imemaddr` holds until each hit, and `inst_pc` increments by 4 per delivered word.
4. Redirect to 32'h0000_0043 while FIFO holds 2 entries and `ihit`=1 -> FIFO is empty the next cycle, `imemaddr`=32'h40, the discarded word is never delivered, and the next `inst_pc`=32'h40.
5. HALT word 32'hFC000000 at PC 12 -> after its pop `halted`=1, `imemREN`=0 and `inst_valid`=0. A redirect pulse afterwards has no effect.
6. Assert `RST` mid-stream with the FIFO non-empty, asynchronously (not on an edge) -> outputs return to reset values immediately. After release, fetch restarts at `PC_INIT`.
